// File: rtl/axis_adc_mc_regs.sv
// Multichannel ADC capture register bank on the up_* bus: staging/commit, go pulses and irq.
// Define AXIS_ADC_MC_REGS_TIMESTAMP_EN to add a 64-bit cycle counter readable at 0x08/0x09.
module axis_adc_mc_regs #(
  parameter logic [31:0] ID     = 32'd0,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                 axim_clk,
  input  logic                 axim_rst,
  input  logic                 up_wreq,
  input  logic [13:0]          up_waddr,
  input  logic [31:0]          up_wdata,
  output logic                 up_wack,
  input  logic                 up_rreq,
  input  logic [13:0]          up_raddr,
  output logic [31:0]          up_rdata,
  output logic                 up_rack,
  output logic [NUM_CH*32-1:0] ch_data_len,
  output logic [NUM_CH*32-1:0] ch_wr_addr_0,
  output logic [NUM_CH*32-1:0] ch_wr_addr_1,
  output logic [NUM_CH-1:0]    ch_go,
  input  logic [NUM_CH-1:0]    ch_done,
  input  logic [NUM_CH-1:0]    ch_overflow,
  input  logic [NUM_CH*4-1:0]  ch_buf_index,
  input  logic [NUM_CH*32-1:0] ch_write_count,
  output logic                 irq
);
  localparam logic [31:0] Version = 32'h0006_0063;
  localparam logic [7:0]  ChMask  = 8'((1 << NUM_CH) - 1);
  localparam logic [15:0] EvtMask = {ChMask, ChMask};
  localparam logic [3:0]  NumChW  = 4'(NUM_CH);

  logic                    wsel, rsel, w_ch_hit, r_ch_hit;
  logic [5:0]              w_off, r_off;
  logic [15:0]             w1c;
  logic [NUM_CH-1:0][31:0] len_s_q, len_s_d, a0_s_q, a0_s_d, a1_s_q, a1_s_d;
  logic [NUM_CH-1:0][31:0] len_c_q, len_c_d, a0_c_q, a0_c_d, a1_c_q, a1_c_d;
  logic [NUM_CH-1:0]       go_q, go_d, busy_q, busy_d, done_q, ovf_q;
  logic [NUM_CH-1:0]       go_req, done_rise, ovf_rise;
  logic [31:0]             scratch_q, scratch_d, irq_en_q, irq_en_d;
  logic [15:0]             irq_sts_q, irq_sts_d;
  logic                    armed_q, irq_q, wack_q, rack_q;
  logic [31:0]             rdata_q, rd_val, ts_lo, ts_hi;

  assign wsel     = up_wreq && (up_waddr[13:8] == 6'd0);
  assign rsel     = up_rreq && (up_raddr[13:8] == 6'd0);
  assign w_off    = 6'(up_waddr[7:0] - 8'h10);
  assign r_off    = 6'(up_raddr[7:0] - 8'h10);
  assign w_ch_hit = wsel && (up_waddr[7:0] >= 8'h10) && (up_waddr[7:0] < 8'h50) &&
                    ({1'b0, w_off[5:3]} < NumChW);
  assign r_ch_hit = rsel && (up_raddr[7:0] >= 8'h10) && (up_raddr[7:0] < 8'h50) &&
                    ({1'b0, r_off[5:3]} < NumChW);
  assign w1c      = (wsel && (up_waddr[7:0] == 8'h03)) ? up_wdata[15:0] : 16'd0;

`ifdef AXIS_ADC_MC_REGS_TIMESTAMP_EN
  logic [63:0] ts_q;
  logic [31:0] ts_hi_q;

  // Reading the low word freezes the high word so a 0x08/0x09 pair is coherent.
  always_ff @(posedge axim_clk) begin
    if (axim_rst) begin
      ts_q    <= '0;
      ts_hi_q <= '0;
    end else begin
      ts_q <= ts_q + 64'd1;
      if (rsel && (up_raddr[7:0] == 8'h08)) ts_hi_q <= ts_q[63:32];
    end
  end
  assign ts_lo = ts_q[31:0];
  assign ts_hi = ts_hi_q;
`else
  assign ts_lo = '0;
  assign ts_hi = '0;
`endif

  // Edges are masked on the first cycle after reset so already-high inputs don't fire.
  always_comb begin
    scratch_d = scratch_q;
    irq_en_d  = irq_en_q;
    len_s_d   = len_s_q;
    a0_s_d    = a0_s_q;
    a1_s_d    = a1_s_q;
    len_c_d   = len_c_q;
    a0_c_d    = a0_c_q;
    a1_c_d    = a1_c_q;
    busy_d    = busy_q;
    go_d      = '0;
    go_req    = '0;
    done_rise = armed_q ? (ch_done & ~done_q) : '0;
    ovf_rise  = armed_q ? (ch_overflow & ~ovf_q) : '0;
    if (wsel && (up_waddr[7:0] == 8'h02)) scratch_d = up_wdata;
    if (wsel && (up_waddr[7:0] == 8'h04)) irq_en_d = up_wdata;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ch_hit && (w_off[5:3] == 3'(n))) begin
        case (w_off[2:0])
          3'd0:    go_req[n] = up_wdata[0];
          3'd1:    len_s_d[n] = up_wdata;
          3'd2:    a0_s_d[n] = up_wdata;
          3'd3:    a1_s_d[n] = up_wdata;
          default: ;
        endcase
      end
      if (wsel && (up_waddr[7:0] == 8'h05) && up_wdata[0]) go_req[n] = 1'b1;
      if (go_req[n] && !busy_q[n]) begin
        go_d[n]    = 1'b1;
        busy_d[n]  = 1'b1;
        len_c_d[n] = len_s_q[n];
        a0_c_d[n]  = a0_s_q[n];
        a1_c_d[n]  = a1_s_q[n];
      end else if (done_rise[n]) begin
        busy_d[n] = 1'b0;
      end
    end
    // Set wins over a simultaneous write-one-to-clear.
    irq_sts_d = ((irq_sts_q & ~w1c) | {8'(ovf_rise), 8'(done_rise)}) & EvtMask;
  end

  always_comb begin
    rd_val = '0;
    case (up_raddr[7:0])
      8'h00:   rd_val = Version;
      8'h01:   rd_val = ID;
      8'h02:   rd_val = scratch_q;
      8'h03:   rd_val = {16'd0, irq_sts_q};
      8'h04:   rd_val = irq_en_q;
      8'h08:   rd_val = ts_lo;
      8'h09:   rd_val = ts_hi;
      default: ;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (r_ch_hit && (r_off[5:3] == 3'(n))) begin
        case (r_off[2:0])
          3'd1:    rd_val = len_s_q[n];
          3'd2:    rd_val = a0_s_q[n];
          3'd3:    rd_val = a1_s_q[n];
          3'd4:    rd_val = {25'd0, ch_buf_index[n*4 +: 4], busy_q[n], ch_overflow[n], ch_done[n]};
          3'd5:    rd_val = ch_write_count[n*32 +: 32];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge axim_clk) begin
    if (axim_rst) begin
      len_s_q   <= '0;
      a0_s_q    <= '0;
      a1_s_q    <= '0;
      len_c_q   <= '0;
      a0_c_q    <= '0;
      a1_c_q    <= '0;
      go_q      <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      ovf_q     <= '0;
      scratch_q <= '0;
      irq_en_q  <= '0;
      irq_sts_q <= '0;
      armed_q   <= 1'b0;
      irq_q     <= 1'b0;
      wack_q    <= 1'b0;
      rack_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      len_s_q   <= len_s_d;
      a0_s_q    <= a0_s_d;
      a1_s_q    <= a1_s_d;
      len_c_q   <= len_c_d;
      a0_c_q    <= a0_c_d;
      a1_c_q    <= a1_c_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      done_q    <= ch_done;
      ovf_q     <= ch_overflow;
      scratch_q <= scratch_d;
      irq_en_q  <= irq_en_d;
      irq_sts_q <= irq_sts_d;
      armed_q   <= 1'b1;
      irq_q     <= |(irq_sts_q & irq_en_q[15:0]);
      wack_q    <= wsel;
      rack_q    <= rsel;
      rdata_q   <= rsel ? rd_val : '0;
    end
  end

  assign up_wack      = wack_q;
  assign up_rack      = rack_q;
  assign up_rdata     = rdata_q;
  assign ch_go        = go_q;
  assign ch_data_len  = len_c_q;
  assign ch_wr_addr_0 = a0_c_q;
  assign ch_wr_addr_1 = a1_c_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_axis_adc_mc_regs.sv
// Bench for axis_adc_mc_regs: directed vector table, hand sequences, then random traffic
// checked cycle by cycle against a transaction-level model of the register map.
`timescale 1ns/1ps
module tb_axis_adc_mc_regs;
  localparam int unsigned NCH  = 2;
  localparam logic [31:0] TbId = 32'hA5C0_0001;

  logic            axim_clk = 1'b0;
  logic            axim_rst;
  logic            up_wreq, up_rreq, up_wack, up_rack;
  logic [13:0]     up_waddr, up_raddr;
  logic [31:0]     up_wdata, up_rdata;
  logic [NCH*32-1:0] ch_data_len, ch_wr_addr_0, ch_wr_addr_1, ch_write_count;
  logic [NCH-1:0]  ch_go, ch_done, ch_overflow;
  logic [NCH*4-1:0] ch_buf_index;
  logic            irq;

  int checks = 0;
  int failures = 0;

  axis_adc_mc_regs #(.ID(TbId), .NUM_CH(NCH)) dut (
    .axim_clk(axim_clk), .axim_rst(axim_rst),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .ch_data_len(ch_data_len), .ch_wr_addr_0(ch_wr_addr_0), .ch_wr_addr_1(ch_wr_addr_1),
    .ch_go(ch_go), .ch_done(ch_done), .ch_overflow(ch_overflow),
    .ch_buf_index(ch_buf_index), .ch_write_count(ch_write_count), .irq(irq)
  );

  always #5 axim_clk = ~axim_clk;

  // Reference model: register contents and the expected registered outputs.
  logic [31:0] m_scratch, m_en, m_status;
  logic [31:0] m_stage [NCH][4];
  logic [31:0] m_commit [NCH][4];
  bit          m_busy [NCH];
  bit          m_prev_done [NCH];
  bit          m_prev_ovf [NCH];
  bit          m_armed;
  logic        e_wack, e_rack, e_irq, e_skip;
  logic [31:0] e_rdata;
  logic [NCH-1:0] e_go;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_scratch = '0; m_en = '0; m_status = '0; m_armed = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      for (int k = 0; k < 4; k++) begin
        m_stage[n][k] = '0;
        m_commit[n][k] = '0;
      end
      m_busy[n] = 0; m_prev_done[n] = 0; m_prev_ovf[n] = 0;
    end
    e_wack = 0; e_rack = 0; e_irq = 0; e_rdata = '0; e_go = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] a);
    int av, ch, r;
    av = int'(a[7:0]);
    case (av)
      0: return 32'h0006_0063;
      1: return TbId;
      2: return m_scratch;
      3: return m_status;
      4: return m_en;
      default: ;
    endcase
    if (av >= 16 && av < 16 + 8 * int'(NCH)) begin
      ch = (av - 16) / 8;
      r  = (av - 16) % 8;
      if (r >= 1 && r <= 3) return m_stage[ch][r];
      if (r == 4) return {25'd0, ch_buf_index[ch*4 +: 4], m_busy[ch], ch_overflow[ch], ch_done[ch]};
      if (r == 5) return ch_write_count[ch*32 +: 32];
    end
    return 32'd0;
  endfunction

  function automatic void model_step(input bit rst, input bit wr, input logic [13:0] wa,
                                     input logic [31:0] wd, input bit rd, input logic [13:0] ra);
    logic [NCH-1:0] go_mask;
    logic [31:0] w1c, set;
    int av, ch, r;
    e_skip = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    e_irq   = |(m_status & m_en);
    e_rack  = rd && (ra[13:8] == 6'd0);
    e_rdata = e_rack ? model_read(ra) : 32'd0;
`ifdef AXIS_ADC_MC_REGS_TIMESTAMP_EN
    if (e_rack && (ra[7:0] == 8'h08 || ra[7:0] == 8'h09)) e_skip = 1'b1;
`endif
    e_wack  = wr && (wa[13:8] == 6'd0);
    go_mask = '0; w1c = '0; set = '0;
    for (int n = 0; n < NCH; n++) begin
      if (m_armed && ch_done[n] && !m_prev_done[n]) set[n] = 1'b1;
      if (m_armed && ch_overflow[n] && !m_prev_ovf[n]) set[8+n] = 1'b1;
    end
    if (e_wack) begin
      av = int'(wa[7:0]);
      if (av == 2) m_scratch = wd;
      else if (av == 3) w1c = wd;
      else if (av == 4) m_en = wd;
      else if (av == 5) begin
        if (wd[0]) go_mask = '1;
      end else if (av >= 16 && av < 16 + 8 * int'(NCH)) begin
        ch = (av - 16) / 8;
        r  = (av - 16) % 8;
        if (r == 0 && wd[0]) go_mask[ch] = 1'b1;
        else if (r >= 1 && r <= 3) m_stage[ch][r] = wd;
      end
    end
    e_go = '0;
    for (int n = 0; n < NCH; n++) begin
      if (go_mask[n] && !m_busy[n]) begin
        e_go[n] = 1'b1;
        m_busy[n] = 1;
        for (int k = 1; k < 4; k++) m_commit[n][k] = m_stage[n][k];
      end else if (set[n]) begin
        m_busy[n] = 0;
      end
      m_prev_done[n] = ch_done[n];
      m_prev_ovf[n]  = ch_overflow[n];
    end
    m_status = (m_status & ~w1c) | set;
    m_armed  = 1;
  endfunction

  task automatic compare_all();
    logic [NCH*32-1:0] x_len, x_a0, x_a1;
    for (int n = 0; n < NCH; n++) begin
      x_len[n*32 +: 32] = m_commit[n][1];
      x_a0[n*32 +: 32]  = m_commit[n][2];
      x_a1[n*32 +: 32]  = m_commit[n][3];
    end
    chk("wack", up_wack, e_wack);
    chk("rack", up_rack, e_rack);
    if (!e_skip) chk("rdata", up_rdata, e_rdata);
    chk("ch_go", ch_go, e_go);
    chk("ch_data_len", ch_data_len, x_len);
    chk("ch_wr_addr_0", ch_wr_addr_0, x_a0);
    chk("ch_wr_addr_1", ch_wr_addr_1, x_a1);
    chk("irq", irq, e_irq);
  endtask

  task automatic cycle(input bit rst, input bit wr, input logic [13:0] wa, input logic [31:0] wd,
                       input bit rd, input logic [13:0] ra);
    axim_rst = rst; up_wreq = wr; up_waddr = wa; up_wdata = wd; up_rreq = rd; up_raddr = ra;
    model_step(rst, wr, wa, wd, rd, ra);
    @(posedge axim_clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(0, 0, 14'h0, 32'h0, 0, 14'h0);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    cycle(0, 1, a, d, 0, 14'h0);
  endtask

  task automatic rd(input logic [13:0] a);
    cycle(0, 0, 14'h0, 32'h0, 1, a);
  endtask

  function automatic logic [13:0] rand_addr();
    logic [13:0] a;
    a = '0;
    if ($urandom_range(0, 3) == 0) a[7:0] = 8'($urandom_range(0, 9));
    else a[7:0] = 8'(8'h10 + $urandom_range(0, 31));
    if ($urandom_range(0, 9) == 0) a[13:8] = 6'($urandom_range(1, 63));
    return a;
  endfunction

  typedef struct {
    bit          wr;
    bit          rd;
    logic [13:0] addr;
    logic [31:0] data;
    bit          ack;
    logic [31:0] rdata;
    logic [1:0]  go;
    logic [31:0] len0;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] lo1, hi1, lo2, hi2;
    axim_rst = 1; up_wreq = 0; up_rreq = 0; up_waddr = '0; up_raddr = '0; up_wdata = '0;
    ch_done = '0; ch_overflow = '0; ch_buf_index = 8'h35; ch_write_count = {32'h2222, 32'h1111};
    model_reset();
    repeat (3) cycle(1, 0, 14'h0, 32'h0, 0, 14'h0);

    //              wr    rd    addr     data          ack   rdata          go     len0
    vecs.push_back('{1'b0, 1'b1, 14'h000, 32'h0,        1'b1, 32'h0006_0063, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 14'h001, 32'h0,        1'b1, TbId,          2'b00, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 14'h002, 32'h0,        1'b1, 32'h0,         2'b00, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 14'h002, 32'hCAFEF00D, 1'b1, 32'h0,         2'b00, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 14'h002, 32'h0,        1'b1, 32'hCAFEF00D,  2'b00, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 14'h011, 32'h400,      1'b1, 32'h0,         2'b00, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 14'h012, 32'h1000_0000, 1'b1, 32'h0,        2'b00, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 14'h011, 32'h0,        1'b1, 32'h400,       2'b00, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 14'h010, 32'h1,        1'b1, 32'h0,         2'b01, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h014, 32'h0,        1'b1, 32'h2C,        2'b00, 32'h400});
    vecs.push_back('{1'b1, 1'b0, 14'h010, 32'h1,        1'b1, 32'h0,         2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h01C, 32'h0,        1'b1, 32'h18,        2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h015, 32'h0,        1'b1, 32'h1111,      2'b00, 32'h400});
    vecs.push_back('{1'b1, 1'b0, 14'h021, 32'hDEAD,     1'b1, 32'h0,         2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h021, 32'h0,        1'b1, 32'h0,         2'b00, 32'h400});
    vecs.push_back('{1'b1, 1'b0, 14'h102, 32'h5555,     1'b0, 32'h0,         2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h102, 32'h0,        1'b0, 32'h0,         2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h002, 32'h0,        1'b1, 32'hCAFEF00D,  2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h006, 32'h0,        1'b1, 32'h0,         2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h010, 32'h0,        1'b1, 32'h0,         2'b00, 32'h400});
`ifndef AXIS_ADC_MC_REGS_TIMESTAMP_EN
    vecs.push_back('{1'b0, 1'b1, 14'h008, 32'h0,        1'b1, 32'h0,         2'b00, 32'h400});
    vecs.push_back('{1'b0, 1'b1, 14'h009, 32'h0,        1'b1, 32'h0,         2'b00, 32'h400});
`endif

    foreach (vecs[i]) begin
      cycle(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].addr);
      if (vecs[i].wr) chk($sformatf("vec%0d_wack", i), up_wack, vecs[i].ack);
      if (vecs[i].rd) chk($sformatf("vec%0d_rack", i), up_rack, vecs[i].ack);
      chk($sformatf("vec%0d_rdata", i), up_rdata, vecs[i].rdata);
      chk($sformatf("vec%0d_go", i), ch_go, vecs[i].go);
      chk($sformatf("vec%0d_len0", i), ch_data_len[31:0], vecs[i].len0);
    end
    idle();
    chk("ack_one_cycle", {up_wack, up_rack}, 2'b00);

    // Done clears busy, then go is accepted.
    ch_done[0] = 1'b1; idle();
    rd(14'h003); chk("done_sets_status", up_rdata, 32'h1);
    wr(14'h010, 32'h1); chk("go_after_done", ch_go, 2'b01);
    ch_done[0] = 1'b0; idle();

    // irq is registered; set beats a same-cycle W1C.
    wr(14'h003, 32'hFFFF_FFFF);
    wr(14'h004, 32'h1);
    idle(); chk("irq_low_after_clear", irq, 1'b0);
    ch_done[0] = 1'b1; idle(); chk("irq_not_yet", irq, 1'b0);
    idle(); chk("irq_asserts", irq, 1'b1);
    ch_done[0] = 1'b0; idle();
    ch_done[0] = 1'b1; wr(14'h003, 32'h1);
    rd(14'h003); chk("w1c_vs_set", up_rdata, 32'h1);
    wr(14'h003, 32'h1);
    rd(14'h003); chk("w1c_clears", up_rdata, 32'h0);
    chk("irq_deasserts", irq, 1'b0);
    ch_overflow[1] = 1'b1; idle();
    rd(14'h003); chk("ovf_sets_status", up_rdata, 32'h200);
    ch_overflow[1] = 1'b0;

    // Global start commits every channel.
    wr(14'h019, 32'h800);
    wr(14'h005, 32'h1);
    chk("go_all", ch_go, 2'b11);
    chk("commit_ch1", ch_data_len[63:32], 32'h800);
    idle(); chk("go_one_cycle", ch_go, 2'b00);

    // Reset mid-capture with done already high.
    ch_done = 2'b00; idle();
    ch_done = 2'b01;
    cycle(1, 1, 14'h005, 32'h1, 0, 14'h0); chk("no_go_in_reset", ch_go, 2'b00);
    cycle(1, 0, 14'h0, 32'h0, 0, 14'h0); chk("len_cleared", ch_data_len, '0);
    idle();
    rd(14'h003); chk("no_edge_after_reset", up_rdata, 32'h0);
    rd(14'h014); chk("busy_cleared_by_reset", up_rdata, 32'h29);
    ch_done = 2'b00; idle();

`ifdef AXIS_ADC_MC_REGS_TIMESTAMP_EN
    rd(14'h008); lo1 = up_rdata;
    rd(14'h009); hi1 = up_rdata;
    repeat (5) idle();
    rd(14'h008); lo2 = up_rdata;
    rd(14'h009); hi2 = up_rdata;
    chk("ts_delta", {hi2, lo2} - {hi1, lo1}, 64'd7);
`endif

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int idx;
        idx = int'($urandom_range(0, NCH - 1));
        if ($urandom_range(0, 1) == 0) ch_done[idx] = ~ch_done[idx];
        else ch_overflow[idx] = ~ch_overflow[idx];
      end
      if ($urandom_range(0, 7) == 0) begin
        ch_buf_index = 8'($urandom);
        ch_write_count = {$urandom, $urandom};
      end
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0), rand_addr(),
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            ($urandom_range(0, 2) == 0), rand_addr());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
